adder_measure_sequencer: RTL and testbench
==========================================

Name: adder_measure_sequencer

Overview:
Initiator-side controller for the instrumented adder macro: it drives the adder's operand and ring-enable/counter controls that the LA bus otherwise drives by hand. Accepts a measurement command (operands, run length) on a valid/ready port, runs one timed ring-oscillator measurement and returns the captured ring count and sum on a valid/ready response port. Sits inside the project wrapper between the LA/io command decode and the instrumented adder.

Parameters:
WIDTH, 32, operand/sum/count width
RUN_W, 24, width of run-length field (clock cycles)
SETTLE_CYCLES, 4, cycles operands are held before ring enable
DRAIN_CYCLES, 3, cycles after ring disable before counter capture (counter sync latency)

Ports:
wb_clk_i  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_a  in  WIDTH  operand a
cmd_b  in  WIDTH  operand b
cmd_run  in  RUN_W  ring-enable duration in clocks
abort  in  1  cancel current measurement
adder_a  out  WIDTH  operand a to adder
adder_b  out  WIDTH  operand b to adder
ring_en  out  1  closes the adder ring loop
cnt_clear  out  1  one-cycle clear of adder ring counter
cnt_en  out  1  ring counter enable
ring_count  in  WIDTH  adder ring counter value
sum  in  WIDTH  adder sum output
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_count  out  WIDTH  captured ring count
rsp_sum  out  WIDTH  captured sum
rsp_aborted  out  1  result is from an aborted run
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert into wb_clk_i domain handled upstream): state=IDLE; all outputs 0 except cmd_ready=1 (cmd_ready=1 only in IDLE).
- States: IDLE, SETTLE, RUN, DRAIN, RESP.
- IDLE: on cmd_valid&cmd_ready latch a, b, run into regs; adder_a/adder_b update next cycle and hold until next accept; cnt_clear=1 for the first SETTLE cycle; -> SETTLE.
- cmd_run==0: treated as 1 (ring_en high exactly one cycle).
- SETTLE: counter counts SETTLE_CYCLES cycles, then -> RUN.
- RUN: ring_en=1, cnt_en=1 for exactly max(cmd_run,1) cycles; down-counter, no wrap; -> DRAIN.
- DRAIN: ring_en=0, cnt_en=1 for DRAIN_CYCLES cycles, then cnt_en=0; on last DRAIN cycle capture ring_count->rsp_count, sum->rsp_sum; -> RESP.
- RESP: rsp_valid=1, rsp_* stable until rsp_valid&rsp_ready; then -> IDLE (cmd_ready=1 next cycle). No command accepted in the same cycle as the response handshake.
- Total command-accept to rsp_valid latency: 1+SETTLE_CYCLES+run+DRAIN_CYCLES cycles.
- abort in SETTLE or RUN: ring_en drops next cycle, go to DRAIN (capture still done), rsp_aborted=1. abort in DRAIN: ignored except rsp_aborted=1. abort in IDLE/RESP: no effect.
- abort and cmd_valid same cycle in IDLE: command accepted, abort ignored.
- ring_en must never be 1 outside RUN; at any reset assertion ring_en and cnt_en go 0 immediately.
- rsp_aborted clears on accept of next command.

Decomposition:
- Shared package adder_meas_pkg: state enum (IDLE, SETTLE, RUN, DRAIN, RESP), default WIDTH/RUN_W constants.
- One sub-module natural: meas_down_counter (loadable RUN_W down-counter with done flag), reused for SETTLE, RUN and DRAIN phases.

Test Plan:
- Reset mid-RUN -> ring_en, cnt_en, rsp_valid drop to 0 asynchronously; cmd_ready=1 after release.
- cmd a=5, b=7, run=100, stub ring_count increments per cnt_en cycle -> ring_en high exactly 100 cycles; rsp_valid at cycle 1+4+100+3=108; rsp_sum=12, rsp_aborted=0.
- run=0 -> ring_en high exactly 1 cycle; rsp_valid at cycle 9.
- abort at RUN cycle 10 of run=1000 -> ring_en low next cycle, rsp_valid 3 cycles later with rsp_aborted=1.
- rsp_ready held 0 for 20 cycles -> rsp_* stable, cmd_ready=0 throughout; back-to-back command accepted the cycle after handshake.
- cmd_valid with abort in IDLE -> command accepted normally, rsp_aborted=0.

Source files
------------

// File: rtl/adder_meas_pkg.sv
// Shared types and defaults for the instrumented-adder measurement sequencer.
package adder_meas_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_RUN_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RUN,
        DRAIN,
        RESP
    } meas_state_e;

    // Down-counter reload value for a phase lasting n cycles (0 behaves as 1).
    function automatic int unsigned phase_load(int unsigned n);
        return (n == 0) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/adder_measure_sequencer_if.sv
// Command/response handshake bundle between the LA/io decode and the sequencer.
interface adder_measure_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int RUN_W = 24
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [RUN_W-1:0] cmd_run;
    logic             abort;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_count;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_aborted;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_run, abort, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_count, rsp_sum, rsp_aborted
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_run, abort, rsp_ready,
        output cmd_ready, rsp_valid, rsp_count, rsp_sum, rsp_aborted
    );
endinterface

// File: rtl/meas_down_counter.sv
// Loadable down-counter shared by all timed phases; done marks the phase's last cycle.
module meas_down_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    // Parks at zero rather than wrapping so an idle counter reads done.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/adder_measure_sequencer.sv
// Runs one timed ring-oscillator measurement on the instrumented adder per command
// and returns the captured ring count and sum.
module adder_measure_sequencer
    import adder_meas_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int RUN_W         = DEF_RUN_W,
    parameter int SETTLE_CYCLES = 4,
    parameter int DRAIN_CYCLES  = 3
) (
    input  logic                     wb_clk_i,
    input  logic                     rst_n,
    adder_measure_sequencer_if.slave bus,
    output logic [WIDTH-1:0]         adder_a,
    output logic [WIDTH-1:0]         adder_b,
    output logic                     ring_en,
    output logic                     cnt_clear,
    output logic                     cnt_en,
    input  logic [WIDTH-1:0]         ring_count,
    input  logic [WIDTH-1:0]         sum,
    output logic                     busy
);
    localparam logic [RUN_W-1:0] SETTLE_LD = RUN_W'(phase_load(SETTLE_CYCLES));
    localparam logic [RUN_W-1:0] DRAIN_LD  = RUN_W'(phase_load(DRAIN_CYCLES));

    meas_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [WIDTH-1:0] count_q, count_d, sum_q, sum_d;
    logic             clear_q, clear_d;
    logic             aborted_q, aborted_d;

    logic             ld;
    logic [RUN_W-1:0] ld_val;
    logic [RUN_W-1:0] run_ld;
    logic             phase_done;

    meas_down_counter #(.W(RUN_W)) u_phase_cnt (
        .clk      (wb_clk_i),
        .rst_n    (rst_n),
        .load     (ld),
        .load_val (ld_val),
        .done     (phase_done)
    );

    // A zero run length still opens the ring for a single cycle.
    assign run_ld = (run_q == '0) ? '0 : run_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        run_d     = run_q;
        count_d   = count_q;
        sum_d     = sum_q;
        clear_d   = 1'b0;
        aborted_d = aborted_q;
        ld        = 1'b0;
        ld_val    = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d   = SETTLE;
                    a_d       = bus.cmd_a;
                    b_d       = bus.cmd_b;
                    run_d     = bus.cmd_run;
                    clear_d   = 1'b1;
                    aborted_d = 1'b0;
                    ld        = 1'b1;
                    ld_val    = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_d   = DRAIN;
                    aborted_d = 1'b1;
                    ld        = 1'b1;
                    ld_val    = DRAIN_LD;
                end else if (phase_done) begin
                    state_d = RUN;
                    ld      = 1'b1;
                    ld_val  = run_ld;
                end
            end
            RUN: begin
                if (bus.abort || phase_done) begin
                    state_d = DRAIN;
                    ld      = 1'b1;
                    ld_val  = DRAIN_LD;
                end
                if (bus.abort) begin
                    aborted_d = 1'b1;
                end
            end
            DRAIN: begin
                // Counter keeps counting here so the synchroniser in the macro can catch up.
                if (bus.abort) begin
                    aborted_d = 1'b1;
                end
                if (phase_done) begin
                    state_d = RESP;
                    count_d = ring_count;
                    sum_d   = sum;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            run_q     <= '0;
            count_q   <= '0;
            sum_q     <= '0;
            clear_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            run_q     <= run_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
            clear_q   <= clear_d;
            aborted_q <= aborted_d;
        end
    end

    // Ring and counter enables decode straight from the state flop so reset kills them at once.
    assign ring_en   = (state_q == RUN);
    assign cnt_en    = (state_q == RUN) || (state_q == DRAIN);
    assign cnt_clear = clear_q;
    assign busy      = (state_q != IDLE);
    assign adder_a   = a_q;
    assign adder_b   = b_q;

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_count   = count_q;
    assign bus.rsp_sum     = sum_q;
    assign bus.rsp_aborted = aborted_q;

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Self-checking bench: stub ring counter, cycle-level observation and an arithmetic model.
module tb_adder_measure_sequencer;
    localparam int S = 4;
    localparam int D = 3;

    typedef struct {
        logic        acc;
        int          lat;
        int          ring;
        int          gaps_bad;
        int          clr_n;
        int          clr_at;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [31:0] cnt;
        logic [31:0] sm;
        logic        ab;
    } meas_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adder_a, adder_b, ring_count, sum;
    logic        ring_en, cnt_clear, cnt_en, busy;
    int          n_chk = 0;
    int          n_fail = 0;

    adder_measure_sequencer_if #(.WIDTH(32), .RUN_W(24)) bus ();

    adder_measure_sequencer #(.WIDTH(32), .RUN_W(24), .SETTLE_CYCLES(S), .DRAIN_CYCLES(D)) dut (
        .wb_clk_i   (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .ring_en    (ring_en),
        .cnt_clear  (cnt_clear),
        .cnt_en     (cnt_en),
        .ring_count (ring_count),
        .sum        (sum),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stub adder macro: ring counter ticks once per enabled cycle.
    assign sum = adder_a + adder_b;
    always @(posedge clk) begin
        if (cnt_clear) ring_count <= 32'd0;
        else if (cnt_en) ring_count <= ring_count + 32'd1;
    end

    // Expected outcome from cycle arithmetic: cycle 1 is the first cycle after the accept.
    function automatic void model(input int run, input int abort_cyc,
                                  output int ring, output int lat, output int cnt, output logic ab);
        int eff;
        eff = (run == 0) ? 1 : run;
        ring = eff;
        ab = 1'b0;
        lat = 1 + S + eff + D;
        if (abort_cyc >= 1 && abort_cyc <= S) begin
            ring = 0; ab = 1'b1; lat = abort_cyc + D + 1;
        end else if (abort_cyc > S && abort_cyc <= S + eff) begin
            ring = abort_cyc - S; ab = 1'b1; lat = 1 + S + ring + D;
        end else if (abort_cyc > S + eff && abort_cyc <= S + eff + D) begin
            ab = 1'b1;
        end
        cnt = ring + D - 1;
    endfunction

    // Issue one command at a negedge and observe until rsp_valid; no checking here.
    task automatic measure(input logic [31:0] a, input logic [31:0] b, input logic [23:0] run,
                           input int abort_cyc, output meas_t m);
        int first;
        first = -1;
        m.ring = 0; m.gaps_bad = 0; m.clr_n = 0; m.clr_at = -1; m.lat = -1;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_run = run; bus.cmd_valid = 1'b1;
        bus.abort = (abort_cyc == 0);
        m.acc = bus.cmd_ready;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.abort = 1'b0;
        m.aa = adder_a; m.bb = adder_b;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            if (ring_en) begin
                if (first < 0) first = cyc;
                else if (cyc != first + m.ring) m.gaps_bad++;
                if (!cnt_en) m.gaps_bad++;
                m.ring++;
            end
            if (cnt_clear) begin m.clr_n++; m.clr_at = cyc; end
            if (bus.rsp_valid) begin m.lat = cyc; break; end
            bus.abort = (cyc == abort_cyc);
            @(negedge clk);
        end
        bus.abort = 1'b0;
        m.cnt = bus.rsp_count; m.sm = bus.rsp_sum; m.ab = bus.rsp_aborted;
    endtask

    // Hold rsp_ready low, then complete the handshake; optionally present a command meanwhile.
    task automatic handshake(input int hold, input bit cmd_during,
                             output int bad, output logic rdy_after, output logic vld_after);
        logic [31:0] c0, s0;
        logic        a0;
        c0 = bus.rsp_count; s0 = bus.rsp_sum; a0 = bus.rsp_aborted;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_count !== c0 || bus.rsp_sum !== s0 ||
                bus.rsp_aborted !== a0 || bus.cmd_ready !== 1'b0) bad++;
        end
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = cmd_during;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        rdy_after = bus.cmd_ready;
        vld_after = bus.rsp_valid;
    endtask

    task automatic test_reset();
        #3;
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b exp 1", bus.cmd_ready); end
        n_chk++; if ({ring_en, cnt_en, cnt_clear, bus.rsp_valid, busy, bus.rsp_aborted} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b exp 000000", {ring_en, cnt_en, cnt_clear, bus.rsp_valid, busy, bus.rsp_aborted}); end
        n_chk++; if ((adder_a | adder_b | bus.rsp_count | bus.rsp_sum) !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: got %h exp 0", adder_a | adder_b | bus.rsp_count | bus.rsp_sum); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        meas_t m; int bad; logic r, v;
        measure(32'd5, 32'd7, 24'd100, -1, m);
        n_chk++; if (m.acc !== 1'b1) begin n_fail++; $display("FAIL basic_acc: got %b exp 1", m.acc); end
        n_chk++; if (m.lat != 108) begin n_fail++; $display("FAIL basic_lat: got %0d exp 108", m.lat); end
        n_chk++; if (m.ring != 100 || m.gaps_bad != 0) begin n_fail++; $display("FAIL basic_ring: got %0d gaps %0d exp 100 gaps 0", m.ring, m.gaps_bad); end
        n_chk++; if (m.clr_n != 1 || m.clr_at != 1) begin n_fail++; $display("FAIL basic_clear: got n=%0d at %0d exp n=1 at 1", m.clr_n, m.clr_at); end
        n_chk++; if (m.aa !== 32'd5 || m.bb !== 32'd7) begin n_fail++; $display("FAIL basic_operands: got %0d,%0d exp 5,7", m.aa, m.bb); end
        n_chk++; if (m.sm !== 32'd12) begin n_fail++; $display("FAIL basic_sum: got %0d exp 12", m.sm); end
        n_chk++; if (m.cnt !== 32'd102) begin n_fail++; $display("FAIL basic_count: got %0d exp 102", m.cnt); end
        n_chk++; if (m.ab !== 1'b0) begin n_fail++; $display("FAIL basic_aborted: got %b exp 0", m.ab); end
        handshake(0, 1'b0, bad, r, v);
        n_chk++; if (r !== 1'b1 || v !== 1'b0) begin n_fail++; $display("FAIL basic_hs: got rdy=%b vld=%b exp 1,0", r, v); end
    endtask

    task automatic test_run_zero();
        meas_t m; int bad; logic r, v;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        measure(a, b, 24'd0, -1, m);
        n_chk++; if (m.ring != 1 || m.gaps_bad != 0) begin n_fail++; $display("FAIL run0_ring: got %0d exp 1", m.ring); end
        n_chk++; if (m.lat != 9) begin n_fail++; $display("FAIL run0_lat: got %0d exp 9", m.lat); end
        n_chk++; if (m.sm !== a + b || m.cnt !== 32'd3) begin n_fail++; $display("FAIL run0_rsp: got sum %h cnt %0d exp %h 3", m.sm, m.cnt, a + b); end
        handshake(0, 1'b0, bad, r, v);
    endtask

    task automatic test_abort();
        meas_t m; int bad; logic r, v;
        measure($urandom, $urandom, 24'd1000, S + 10, m);
        n_chk++; if (m.ring != 10 || m.gaps_bad != 0) begin n_fail++; $display("FAIL abort_run_ring: got %0d exp 10", m.ring); end
        n_chk++; if (m.lat != 18) begin n_fail++; $display("FAIL abort_run_lat: got %0d exp 18", m.lat); end
        n_chk++; if (m.ab !== 1'b1 || m.cnt !== 32'd12) begin n_fail++; $display("FAIL abort_run_rsp: got ab=%b cnt=%0d exp 1 12", m.ab, m.cnt); end
        handshake(0, 1'b0, bad, r, v);
        measure($urandom, $urandom, 24'd20, 2, m);
        n_chk++; if (m.ring != 0 || m.lat != 2 + D + 1 || m.ab !== 1'b1 || m.cnt !== 32'(D - 1)) begin
            n_fail++; $display("FAIL abort_settle: got ring=%0d lat=%0d ab=%b cnt=%0d exp 0 %0d 1 %0d", m.ring, m.lat, m.ab, m.cnt, D + 2 + 1, D - 1); end
        handshake(0, 1'b0, bad, r, v);
        measure($urandom, $urandom, 24'd20, S + 20 + 1, m);
        n_chk++; if (m.ring != 20 || m.lat != 28 || m.ab !== 1'b1) begin
            n_fail++; $display("FAIL abort_drain: got ring=%0d lat=%0d ab=%b exp 20 28 1", m.ring, m.lat, m.ab); end
        handshake(0, 1'b0, bad, r, v);
        measure($urandom, $urandom, 24'd20, 0, m);
        n_chk++; if (m.acc !== 1'b1 || m.ring != 20 || m.lat != 28 || m.ab !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got acc=%b ring=%0d lat=%0d ab=%b exp 1 20 28 0", m.acc, m.ring, m.lat, m.ab); end
        handshake(0, 1'b0, bad, r, v);
    endtask

    task automatic test_back_to_back();
        meas_t m; int bad; logic r, v;
        measure(32'hFFFF_FFFF, 32'd2, 24'd7, -1, m);
        n_chk++; if (m.sm !== 32'd1) begin n_fail++; $display("FAIL bp_sum_wrap: got %h exp 1", m.sm); end
        handshake(20, 1'b1, bad, r, v);
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL bp_stable: got %0d bad cycles exp 0", bad); end
        n_chk++; if (r !== 1'b1 || v !== 1'b0) begin n_fail++; $display("FAIL bp_release: got rdy=%b vld=%b exp 1,0", r, v); end
        measure(32'd100, 32'd23, 24'd3, -1, m);
        n_chk++; if (m.acc !== 1'b1 || m.lat != 1 + S + 3 + D) begin n_fail++; $display("FAIL b2b_lat: got acc=%b lat=%0d exp 1 %0d", m.acc, m.lat, 1 + S + 3 + D); end
        n_chk++; if (m.sm !== 32'd123 || m.cnt !== 32'(3 + D - 1)) begin n_fail++; $display("FAIL b2b_rsp: got sum=%0d cnt=%0d exp 123 %0d", m.sm, m.cnt, 3 + D - 1); end
        handshake(0, 1'b0, bad, r, v);
    endtask

    task automatic test_random();
        meas_t m; int bad; logic r, v;
        int run, ac, e_ring, e_lat, e_cnt, eff;
        logic e_ab;
        logic [31:0] a, b;
        for (int it = 0; it < 10; it++) begin
            a = $urandom; b = $urandom;
            run = $urandom_range(0, 40);
            eff = (run == 0) ? 1 : run;
            ac = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, S + eff + D);
            model(run, ac, e_ring, e_lat, e_cnt, e_ab);
            measure(a, b, 24'(run), ac, m);
            n_chk++; if (m.acc !== 1'b1 || m.lat != e_lat || m.ring != e_ring || m.gaps_bad != 0) begin
                n_fail++; $display("FAIL rand%0d_timing: got acc=%b lat=%0d ring=%0d gaps=%0d exp lat=%0d ring=%0d (run=%0d abort=%0d)",
                                   it, m.acc, m.lat, m.ring, m.gaps_bad, e_lat, e_ring, run, ac); end
            n_chk++; if (m.sm !== a + b || m.cnt !== 32'(e_cnt) || m.ab !== e_ab) begin
                n_fail++; $display("FAIL rand%0d_rsp: got sum=%h cnt=%0d ab=%b exp %h %0d %b", it, m.sm, m.cnt, m.ab, a + b, e_cnt, e_ab); end
            handshake($urandom_range(0, 3), 1'b0, bad, r, v);
            n_chk++; if (bad != 0 || r !== 1'b1) begin n_fail++; $display("FAIL rand%0d_hs: got bad=%0d rdy=%b exp 0 1", it, bad, r); end
        end
    endtask

    task automatic test_reset_mid_run();
        bus.cmd_a = 32'd1; bus.cmd_b = 32'd2; bus.cmd_run = 24'd1000; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (S + 9) @(negedge clk);
        n_chk++; if (ring_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ring: got %b exp 1", ring_en); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({ring_en, cnt_en, bus.rsp_valid, busy} !== 4'b0) begin
            n_fail++; $display("FAIL rst_async: got %b exp 0000", {ring_en, cnt_en, bus.rsp_valid, busy}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.cmd_ready !== 1'b1 || ring_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_release: got rdy=%b ring=%b exp 1 0", bus.cmd_ready, ring_en); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_run = '0;
        bus.abort = 1'b0; bus.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_run_zero();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
